// File: rtl/wisc_pkg.sv
// Shared ISA constants for the flag/branch path: opcodes, condition codes, flag bit positions.
// Also provides the per-opcode flag ownership mask and the redirect FSM state type.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GTE = 3'b100;
    localparam logic [2:0] CC_LTE = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UN  = 3'b111;

    localparam int FZ = 2;
    localparam int FN = 1;
    localparam int FV = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } rd_state_t;

    // Which {Z,N,V} bits an opcode is allowed to write.
    function automatic logic [2:0] flag_owner(input logic [3:0] op);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            OP_ADD, OP_SUB:                 m = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
            default:                        m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Branch condition evaluator: maps a 3-bit ccc and {Z,N,V} to a taken bit.
// Purely combinational, zero latency, no backpressure.
module cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic w_z, w_n, w_v;

    always_comb begin
        w_z   = flags[FZ];
        w_n   = flags[FN];
        w_v   = flags[FV];
        taken = 1'b0;
        case (cond)
            CC_NE:   taken = ~w_z;
            CC_EQ:   taken = w_z;
            CC_GT:   taken = ~w_z & ~w_n;
            CC_LT:   taken = w_n;
            CC_GTE:  taken = w_z | (~w_z & ~w_n);
            CC_LTE:  taken = w_n | w_z;
            CC_OV:   taken = w_v;
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural Z/N/V register with EX bypass, ID branch decision and a registered fetch redirect.
// Flags update one cycle after EX; redirect is held (br_stall) until fetch asserts redirect_ready.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter bit         BYPASS_EN = 1'b1,
    parameter logic [2:0] FLAG_RST  = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic        ex_stall,
    input  logic        ex_flush,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    input  logic        id_br_valid,
    input  logic [2:0]  id_cond,
    input  logic [15:0] id_target,
    input  logic        redirect_ready,
    output logic [2:0]  flags,
    output logic        br_taken,
    output logic        redirect_valid,
    output logic [15:0] redirect_pc,
    output logic        br_stall
);

    logic [2:0]  r_flags;
    rd_state_t   r_state;
    logic        r_redirect_valid;
    logic [15:0] r_redirect_pc;

    logic        w_we;
    logic [2:0]  w_mask;
    logic [2:0]  w_alu;
    logic [2:0]  w_flags_nxt;
    logic [2:0]  w_eff;
    logic        w_cond_ok;
    logic        w_br_taken;
    logic        w_br_stall;

    assign w_we        = ex_valid & ~ex_stall & ~ex_flush;
    assign w_mask      = w_we ? flag_owner(ex_opcode) : 3'b000;
    assign w_alu       = {alu_z, alu_n, alu_v};
    assign w_flags_nxt = (w_mask & w_alu) | (~w_mask & r_flags);
    // The next-state value doubles as the bypassed view: owned bits from the ALU, rest from the register.
    assign w_eff       = BYPASS_EN ? w_flags_nxt : r_flags;

    cond_eval u_cond_eval (
        .cond  (id_cond),
        .flags (w_eff),
        .taken (w_cond_ok)
    );

    assign w_br_taken = id_br_valid & w_cond_ok;
    assign w_br_stall = r_redirect_valid & ~redirect_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags          <= FLAG_RST;
            r_state          <= ST_IDLE;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 16'h0000;
        end else begin
            r_flags <= w_flags_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_br_taken && !w_br_stall) begin
                        r_redirect_pc    <= id_target;
                        r_state          <= ST_PEND;
                        r_redirect_valid <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (redirect_ready) begin
                        if (w_br_taken) begin
                            r_redirect_pc <= id_target;
                        end else begin
                            r_state          <= ST_IDLE;
                            r_redirect_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state          <= ST_IDLE;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    assign flags          = r_flags;
    assign br_taken       = w_br_taken;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign br_stall       = w_br_stall;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: two instances (bypass on/off) driven from shared stimulus.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic        ex_stall;
    logic        ex_flush;
    logic        alu_z, alu_n, alu_v;
    logic        id_br_valid;
    logic [2:0]  id_cond;
    logic [15:0] id_target;
    logic        redirect_ready;

    logic [2:0]  flags,   flags0;
    logic        taken,   taken0;
    logic        rv,      rv0;
    logic [15:0] rpc,     rpc0;
    logic        stall,   stall0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    flag_branch_unit #(.BYPASS_EN(1'b1), .FLAG_RST(3'b000)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_stall(ex_stall), .ex_flush(ex_flush),
        .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
        .id_br_valid(id_br_valid), .id_cond(id_cond), .id_target(id_target),
        .redirect_ready(redirect_ready),
        .flags(flags), .br_taken(taken), .redirect_valid(rv),
        .redirect_pc(rpc), .br_stall(stall)
    );

    flag_branch_unit #(.BYPASS_EN(1'b0), .FLAG_RST(3'b000)) dut_nb (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_stall(ex_stall), .ex_flush(ex_flush),
        .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
        .id_br_valid(id_br_valid), .id_cond(id_cond), .id_target(id_target),
        .redirect_ready(redirect_ready),
        .flags(flags0), .br_taken(taken0), .redirect_valid(rv0),
        .redirect_pc(rpc0), .br_stall(stall0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic [3:0] op, input logic [2:0] a);
        ex_valid  = v;
        ex_opcode = op;
        {alu_z, alu_n, alu_v} = a;
    endtask

    function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] f);
        logic z, n, v;
        z = f[2]; n = f[1]; v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        rst = 1'b1; ex_stall = 1'b0; ex_flush = 1'b0;
        ex_set(1'b0, 4'h0, 3'b000);
        id_br_valid = 1'b0; id_cond = 3'd0; id_target = 16'h0000;
        redirect_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_flags", {29'd0, flags}, 32'h0);
        chk("rst_rv", {31'd0, rv}, 32'h0);
        chk("rst_pc", {16'd0, rpc}, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'h0);

        // SUB writes all three flags
        ex_set(1'b1, 4'h1, 3'b100);
        step();
        chk("sub_flags", {29'd0, flags}, 32'h4);

        // XOR owns Z only; RED owns nothing
        ex_set(1'b1, 4'h0, 3'b011);
        step();
        chk("add_flags", {29'd0, flags}, 32'h3);
        ex_set(1'b1, 4'h2, 3'b100);
        step();
        chk("xor_flags", {29'd0, flags}, 32'h7);
        ex_set(1'b1, 4'h3, 3'b000);
        step();
        chk("red_flags", {29'd0, flags}, 32'h7);

        // Bypass of same-cycle SUB Z into an EQ branch
        ex_set(1'b1, 4'h0, 3'b000);
        step();
        chk("clr_flags", {29'd0, flags}, 32'h0);
        ex_set(1'b1, 4'h1, 3'b100);
        id_br_valid = 1'b1; id_cond = 3'b001; id_target = 16'h0010;
        #1;
        chk("byp_taken", {31'd0, taken}, 32'h1);
        chk("nobyp_taken", {31'd0, taken0}, 32'h0);
        step();
        ex_set(1'b0, 4'h0, 3'b000);
        id_br_valid = 1'b0;
        chk("byp_rv", {31'd0, rv}, 32'h1);
        chk("byp_pc", {16'd0, rpc}, 32'h0010);
        chk("nobyp_rv", {31'd0, rv0}, 32'h0);
        redirect_ready = 1'b1;
        #1;
        chk("byp_stall_rdy", {31'd0, stall}, 32'h0);
        step();
        chk("byp_rv_clr", {31'd0, rv}, 32'h0);

        // Stalled / flushed ADD: no write, no bypass
        redirect_ready = 1'b0;
        ex_set(1'b1, 4'h0, 3'b000);
        step();
        ex_set(1'b1, 4'h0, 3'b100);
        ex_stall = 1'b1;
        id_br_valid = 1'b1; id_cond = 3'b001;
        #1;
        chk("stall_taken", {31'd0, taken}, 32'h0);
        step();
        chk("stall_flags", {29'd0, flags}, 32'h0);
        ex_stall = 1'b0; ex_flush = 1'b1;
        #1;
        chk("flush_taken", {31'd0, taken}, 32'h0);
        step();
        chk("flush_flags", {29'd0, flags}, 32'h0);
        chk("flush_rv", {31'd0, rv}, 32'h0);
        ex_flush = 1'b0;
        ex_set(1'b0, 4'h0, 3'b000);

        // Redirect held while fetch is not ready
        id_cond = 3'b111; id_target = 16'h0040;
        step();
        id_target = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            chk("hold_rv", {31'd0, rv}, 32'h1);
            chk("hold_pc", {16'd0, rpc}, 32'h0040);
            chk("hold_stall", {31'd0, stall}, 32'h1);
            step();
        end
        // Back-to-back: accept and capture a new target together
        redirect_ready = 1'b1; id_target = 16'h0080;
        #1;
        chk("b2b_stall", {31'd0, stall}, 32'h0);
        step();
        chk("b2b_rv", {31'd0, rv}, 32'h1);
        chk("b2b_pc", {16'd0, rpc}, 32'h0080);
        id_br_valid = 1'b0;
        step();
        chk("b2b_rv_clr", {31'd0, rv}, 32'h0);
        chk("b2b_pc_keep", {16'd0, rpc}, 32'h0080);

        // Reset mid-handshake
        redirect_ready = 1'b0;
        ex_set(1'b1, 4'h0, 3'b111);
        step();
        ex_set(1'b0, 4'h0, 3'b000);
        id_br_valid = 1'b1; id_cond = 3'b111; id_target = 16'h0ABC;
        step();
        id_br_valid = 1'b0;
        chk("pre_rst_rv", {31'd0, rv}, 32'h1);
        chk("pre_rst_flags", {29'd0, flags}, 32'h7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_rv", {31'd0, rv}, 32'h0);
        chk("mid_rst_flags", {29'd0, flags}, 32'h0);
        chk("mid_rst_stall", {31'd0, stall}, 32'h0);
        chk("mid_rst_pc", {16'd0, rpc}, 32'h0);

        // Sweep every condition against every flag combination
        redirect_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            ex_set(1'b1, 4'h0, f[2:0]);
            step();
            ex_set(1'b0, 4'h0, 3'b000);
            chk("sweep_flags", {29'd0, flags}, f);
            for (int c = 0; c < 8; c++) begin
                id_br_valid = 1'b1; id_cond = c[2:0];
                #1;
                chk($sformatf("cc%0d_f%0d", c, f), {31'd0, taken},
                    {31'd0, ref_cond(c[2:0], f[2:0])});
                chk($sformatf("nb_cc%0d_f%0d", c, f), {31'd0, taken0},
                    {31'd0, ref_cond(c[2:0], f[2:0])});
            end
            id_br_valid = 1'b0; id_cond = 3'b111;
            #1;
            chk("novalid_taken", {31'd0, taken}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
